// File: rtl/sh2_ext_bus_bridge_pkg.sv
// Shared types for the SH7604 external bus bridge: FSM states, area index and
// the latched memory-port command.
package sh2_ext_bus_bridge_pkg;

  localparam int unsigned ADDR_W = 27;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CS_W   = 4;
  localparam int unsigned CNT_W  = 10;

  typedef enum logic [1:0] {BR_IDLE, BR_ARM, BR_BUSY, BR_DONE} BridgeState_t;

  typedef logic [1:0] BridgeArea_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
    logic              wr;
    BridgeArea_t       area;
  } mem_cmd_t;

  // Lowest-index asserted chip select wins.
  function automatic BridgeArea_t area_of(input logic [CS_W-1:0] cs_n);
    if (!cs_n[0])      return BridgeArea_t'(0);
    else if (!cs_n[1]) return BridgeArea_t'(1);
    else if (!cs_n[2]) return BridgeArea_t'(2);
    else               return BridgeArea_t'(3);
  endfunction

endpackage

// File: rtl/sh2_ext_bus_bridge_tmo.sv
// Saturating bus-cycle timeout counter; expire is registered and reflects
// count == TIMEOUT-1.
module sh2_ext_bus_bridge_tmo
  import sh2_ext_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             expire_d, expire_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expire_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire = expire_q;

endmodule

// File: rtl/sh2_ext_bus_bridge.sv
// SH7604 external bus to single request/acknowledge memory port bridge,
// holding the CPU in WAIT until the slave answers or the timeout fires.
module sh2_ext_bus_bridge
  import sh2_ext_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic [26:0] A,
  input  logic [31:0] DO,
  output logic [31:0] DI,
  input  logic        BS_N,
  input  logic [3:0]  CS_N,
  input  logic        RD_WR_N,
  input  logic        RD_N,
  input  logic [3:0]  WE_N,
  output logic        WAIT_N,
  output logic [26:0] MEM_A,
  output logic [31:0] MEM_DO,
  output logic [3:0]  MEM_BE,
  output logic        MEM_WR,
  output logic [1:0]  MEM_AREA,
  output logic        MEM_REQ,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_DI,
  output logic        BUS_ERR
);

  BridgeState_t state_d, state_q;
  mem_cmd_t     mem_d, mem_q;
  logic [31:0]  di_d, di_q;
  logic         rd_d, rd_q;
  logic         wait_n_d, wait_n_q;
  logic         req_d, req_q;
  logic         bus_err_d, bus_err_q;
  logic         start_c, released_c, tmo_clear_c, tmo_expire;

  assign start_c    = CE_R && !BS_N && (CS_N != 4'hF);
  assign released_c = CE_R && (CS_N == 4'hF);

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    di_d        = di_q;
    rd_d        = rd_q;
    wait_n_d    = wait_n_q;
    req_d       = req_q;
    bus_err_d   = 1'b0;
    tmo_clear_c = 1'b0;

    case (state_q)
      // DONE shares the start decode so a restart in the release sample is not lost.
      BR_IDLE, BR_DONE: begin
        if (start_c) begin
          mem_d.addr = A;
          mem_d.area = area_of(CS_N);
          rd_d       = RD_WR_N;
          wait_n_d   = 1'b0;
          state_d    = BR_ARM;
        end else if ((state_q == BR_DONE) && released_c) begin
          state_d = BR_IDLE;
        end
      end
      BR_ARM: begin
        if (released_c) begin
          wait_n_d = 1'b1;
          state_d  = BR_IDLE;
        end else if (CE_R && rd_q && !RD_N) begin
          mem_d.be    = 4'hF;
          mem_d.wr    = 1'b0;
          req_d       = 1'b1;
          tmo_clear_c = 1'b1;
          state_d     = BR_BUSY;
        end else if (CE_R && !rd_q && (WE_N != 4'hF)) begin
          mem_d.data  = DO;
          mem_d.be    = ~WE_N;
          mem_d.wr    = 1'b1;
          req_d       = 1'b1;
          tmo_clear_c = 1'b1;
          state_d     = BR_BUSY;
        end
      end
      BR_BUSY: begin
        if (MEM_ACK) begin
          req_d    = 1'b0;
          wait_n_d = 1'b1;
          if (rd_q) di_d = MEM_DI;
          state_d  = BR_DONE;
        end else if (tmo_expire) begin
          req_d     = 1'b0;
          wait_n_d  = 1'b1;
          bus_err_d = 1'b1;
          if (rd_q) di_d = ERR_DATA;
          state_d   = BR_DONE;
        end
      end
      default: state_d = BR_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= BR_IDLE;
      mem_q     <= '0;
      di_q      <= '0;
      rd_q      <= 1'b0;
      wait_n_q  <= 1'b1;
      req_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      di_q      <= di_d;
      rd_q      <= rd_d;
      wait_n_q  <= wait_n_d;
      req_q     <= req_d;
      bus_err_q <= bus_err_d;
    end
  end

  sh2_ext_bus_bridge_tmo #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk   (CLK),
    .rst   (RST),
    .clear (tmo_clear_c),
    .run   (state_q == BR_BUSY),
    .expire(tmo_expire)
  );

  assign DI       = di_q;
  assign WAIT_N   = wait_n_q;
  assign MEM_A    = mem_q.addr;
  assign MEM_DO   = mem_q.data;
  assign MEM_BE   = mem_q.be;
  assign MEM_WR   = mem_q.wr;
  assign MEM_AREA = mem_q.area;
  assign MEM_REQ  = req_q;
  assign BUS_ERR  = bus_err_q;

endmodule

// File: tb/tb_sh2_ext_bus_bridge.sv
// Directed bench for sh2_ext_bus_bridge: per-cycle vector table plus
// hand-written timeout, coincidence, reset and back-to-back sequences.
module tb_sh2_ext_bus_bridge;

  logic        clk = 1'b0;
  logic        rst, ce_r, bs_n, rd_wr_n, rd_n, mem_ack;
  logic [3:0]  cs_n, we_n;
  logic [26:0] a;
  logic [31:0] dout, mem_di;
  logic [31:0] di, mem_do;
  logic [26:0] mem_a;
  logic [3:0]  mem_be;
  logic [1:0]  mem_area;
  logic        wait_n, mem_wr, mem_req, bus_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sh2_ext_bus_bridge #(.TIMEOUT(16)) dut (
    .CLK(clk), .RST(rst), .CE_R(ce_r), .A(a), .DO(dout), .DI(di),
    .BS_N(bs_n), .CS_N(cs_n), .RD_WR_N(rd_wr_n), .RD_N(rd_n), .WE_N(we_n),
    .WAIT_N(wait_n), .MEM_A(mem_a), .MEM_DO(mem_do), .MEM_BE(mem_be),
    .MEM_WR(mem_wr), .MEM_AREA(mem_area), .MEM_REQ(mem_req),
    .MEM_ACK(mem_ack), .MEM_DI(mem_di), .BUS_ERR(bus_err)
  );

  typedef struct {
    logic rst, ce, bs_n; logic [3:0] cs_n; logic rdwr, rd_n; logic [3:0] we_n;
    logic [26:0] a; logic [31:0] dout; logic ack; logic [31:0] mdi;
    logic e_wait, e_req, e_err, e_wr; logic [3:0] e_be; logic [1:0] e_area;
    logic [31:0] e_di; logic [26:0] e_ma; logic [31:0] e_mdo;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic r, ce, bsn, input logic [3:0] csn, input logic rw, rdn, input logic [3:0] wen,
    input logic [26:0] ad, input logic [31:0] dd, input logic ak, input logic [31:0] md,
    input logic ew, er, ee, ewr, input logic [3:0] ebe, input logic [1:0] ear,
    input logic [31:0] edi, input logic [26:0] ema, input logic [31:0] emdo);
    vec_t v;
    v.rst = r; v.ce = ce; v.bs_n = bsn; v.cs_n = csn; v.rdwr = rw; v.rd_n = rdn; v.we_n = wen;
    v.a = ad; v.dout = dd; v.ack = ak; v.mdi = md;
    v.e_wait = ew; v.e_req = er; v.e_err = ee; v.e_wr = ewr; v.e_be = ebe; v.e_area = ear;
    v.e_di = edi; v.e_ma = ema; v.e_mdo = emdo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    rst = 1'b0; ce_r = 1'b1; bs_n = 1'b1; cs_n = 4'hF; rd_wr_n = 1'b1; rd_n = 1'b1;
    we_n = 4'hF; a = '0; dout = '0; mem_ack = 1'b0; mem_di = '0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = tbl[i];
    rst = v.rst; ce_r = v.ce; bs_n = v.bs_n; cs_n = v.cs_n; rd_wr_n = v.rdwr; rd_n = v.rd_n;
    we_n = v.we_n; a = v.a; dout = v.dout; mem_ack = v.ack; mem_di = v.mdi;
    tick();
    chk($sformatf("v%0d.wait_n", i), 32'(wait_n), 32'(v.e_wait));
    chk($sformatf("v%0d.req", i), 32'(mem_req), 32'(v.e_req));
    chk($sformatf("v%0d.bus_err", i), 32'(bus_err), 32'(v.e_err));
    chk($sformatf("v%0d.wr", i), 32'(mem_wr), 32'(v.e_wr));
    chk($sformatf("v%0d.be", i), 32'(mem_be), 32'(v.e_be));
    chk($sformatf("v%0d.area", i), 32'(mem_area), 32'(v.e_area));
    chk($sformatf("v%0d.di", i), di, v.e_di);
    chk($sformatf("v%0d.mem_a", i), 32'(mem_a), 32'(v.e_ma));
    chk($sformatf("v%0d.mem_do", i), mem_do, v.e_mdo);
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    //            rst ce bs cs    rw rd we    a            do            ak mdi           w  r  e  wr be    ar di            ma           mdo
    tbl[0]  = mk(1, 1, 1, 4'hF, 1, 1, 4'hF, 27'h0,       32'h0,        0, 32'h0,        1, 0, 0, 0, 4'h0, 0, 32'h0,        27'h0,       32'h0);
    tbl[1]  = mk(0, 1, 0, 4'hE, 1, 1, 4'hF, 27'h0000100, 32'h0,        0, 32'h0,        0, 0, 0, 0, 4'h0, 0, 32'h0,        27'h0000100, 32'h0);
    tbl[2]  = mk(0, 1, 1, 4'hE, 1, 0, 4'hF, 27'h0000100, 32'h0,        0, 32'h0,        0, 1, 0, 0, 4'hF, 0, 32'h0,        27'h0000100, 32'h0);
    for (int i = 3; i <= 6; i++) tbl[i] = tbl[2];
    tbl[7]  = mk(0, 1, 1, 4'hE, 1, 0, 4'hF, 27'h0000100, 32'h0,        1, 32'h12345678, 1, 0, 0, 0, 4'hF, 0, 32'h12345678, 27'h0000100, 32'h0);
    tbl[8]  = mk(0, 1, 1, 4'hF, 1, 1, 4'hF, 27'h0000100, 32'h0,        0, 32'h0,        1, 0, 0, 0, 4'hF, 0, 32'h12345678, 27'h0000100, 32'h0);
    tbl[9]  = mk(0, 1, 0, 4'hB, 0, 1, 4'hF, 27'h0200040, 32'h0,        0, 32'h0,        0, 0, 0, 0, 4'hF, 2, 32'h12345678, 27'h0200040, 32'h0);
    tbl[10] = mk(0, 1, 1, 4'hB, 0, 1, 4'hD, 27'h0200040, 32'hAABBCCDD, 0, 32'h0,        0, 1, 0, 1, 4'h2, 2, 32'h12345678, 27'h0200040, 32'hAABBCCDD);
    tbl[11] = mk(0, 1, 1, 4'hB, 0, 1, 4'hF, 27'h0200040, 32'h0,        1, 32'h55555555, 1, 0, 0, 1, 4'h2, 2, 32'h12345678, 27'h0200040, 32'hAABBCCDD);
    tbl[12] = mk(0, 1, 1, 4'hF, 0, 1, 4'hF, 27'h0200040, 32'h0,        0, 32'h0,        1, 0, 0, 1, 4'h2, 2, 32'h12345678, 27'h0200040, 32'hAABBCCDD);
    tbl[13] = mk(0, 1, 0, 4'h7, 1, 1, 4'hF, 27'h0300000, 32'h0,        0, 32'h0,        0, 0, 0, 1, 4'h2, 3, 32'h12345678, 27'h0300000, 32'hAABBCCDD);
    tbl[14] = mk(0, 1, 1, 4'hF, 1, 0, 4'hF, 27'h0300000, 32'h0,        0, 32'h0,        1, 0, 0, 1, 4'h2, 3, 32'h12345678, 27'h0300000, 32'hAABBCCDD);
    tbl[15] = mk(0, 1, 1, 4'hF, 1, 1, 4'hF, 27'h0,       32'h0,        1, 32'hDEADBEEF, 1, 0, 0, 1, 4'h2, 3, 32'h12345678, 27'h0300000, 32'hAABBCCDD);
    tbl[16] = mk(0, 0, 0, 4'hE, 1, 1, 4'hF, 27'h0400000, 32'h0,        0, 32'h0,        1, 0, 0, 1, 4'h2, 3, 32'h12345678, 27'h0300000, 32'hAABBCCDD);
    tbl[17] = mk(0, 1, 0, 4'hE, 1, 1, 4'hF, 27'h0400000, 32'h0,        0, 32'h0,        0, 0, 0, 1, 4'h2, 0, 32'h12345678, 27'h0400000, 32'hAABBCCDD);
    tbl[18] = mk(0, 0, 1, 4'hE, 1, 0, 4'hF, 27'h0400000, 32'h0,        0, 32'h0,        0, 0, 0, 1, 4'h2, 0, 32'h12345678, 27'h0400000, 32'hAABBCCDD);
    tbl[19] = mk(0, 1, 1, 4'hE, 1, 0, 4'hF, 27'h0400000, 32'h0,        0, 32'h0,        0, 1, 0, 0, 4'hF, 0, 32'h12345678, 27'h0400000, 32'hAABBCCDD);
    tbl[20] = mk(0, 1, 1, 4'hE, 1, 0, 4'hF, 27'h0400000, 32'h0,        1, 32'h0000ABCD, 1, 0, 0, 0, 4'hF, 0, 32'h0000ABCD, 27'h0400000, 32'hAABBCCDD);
    tbl[21] = mk(0, 1, 1, 4'hF, 1, 1, 4'hF, 27'h0400000, 32'h0,        0, 32'h0,        1, 0, 0, 0, 4'hF, 0, 32'h0000ABCD, 27'h0400000, 32'hAABBCCDD);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Timeout on CS1: request lasts exactly 16 CLK, one BUS_ERR, late ACK ignored.
    set_idle(); bs_n = 1'b0; cs_n = 4'hD; a = 27'h0500000;
    tick(); chk("tmo.arm_wait", 32'(wait_n), 32'd0); chk("tmo.area", 32'(mem_area), 32'd1);
    bs_n = 1'b1; rd_n = 1'b0;
    tick(); chk("tmo.req_rise", 32'(mem_req), 32'd1);
    a = 27'h7FFFFFF;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("tmo.req_hold%0d", i), 32'(mem_req), 32'd1);
      chk($sformatf("tmo.err_low%0d", i), 32'(bus_err), 32'd0);
    end
    chk("tmo.addr_stable", 32'(mem_a), 32'h0500000);
    tick();
    chk("tmo.req_drop", 32'(mem_req), 32'd0); chk("tmo.err_pulse", 32'(bus_err), 32'd1);
    chk("tmo.wait_rel", 32'(wait_n), 32'd1); chk("tmo.di_err", di, 32'hFFFFFFFF);
    mem_ack = 1'b1; mem_di = 32'h11111111;
    tick();
    chk("tmo.err_once", 32'(bus_err), 32'd0); chk("tmo.late_ack_di", di, 32'hFFFFFFFF);
    chk("tmo.late_ack_req", 32'(mem_req), 32'd0);
    set_idle(); tick();

    // ACK coincides with expiry; CS0 and CS3 both low selects area 0.
    bs_n = 1'b0; cs_n = 4'b0110; a = 27'h0600000;
    tick(); chk("coin.area", 32'(mem_area), 32'd0);
    bs_n = 1'b1; rd_n = 1'b0;
    tick();
    for (int i = 1; i <= 15; i++) tick();
    chk("coin.req_before", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_di = 32'hCAFEF00D;
    tick();
    chk("coin.di", di, 32'hCAFEF00D); chk("coin.no_err", 32'(bus_err), 32'd0);
    chk("coin.req", 32'(mem_req), 32'd0); chk("coin.wait", 32'(wait_n), 32'd1);
    mem_ack = 1'b0;
    tick(); chk("coin.no_err_after", 32'(bus_err), 32'd0);
    set_idle(); tick();

    // Synchronous reset during BUSY.
    bs_n = 1'b0; cs_n = 4'hE; a = 27'h0700000;
    tick(); bs_n = 1'b1; rd_n = 1'b0;
    tick(); chk("rst.busy_req", 32'(mem_req), 32'd1);
    tick(); rst = 1'b1;
    tick();
    chk("rst.req", 32'(mem_req), 32'd0); chk("rst.wait", 32'(wait_n), 32'd1);
    chk("rst.err", 32'(bus_err), 32'd0); chk("rst.wr", 32'(mem_wr), 32'd0);
    chk("rst.be", 32'(mem_be), 32'd0); chk("rst.area", 32'(mem_area), 32'd0);
    chk("rst.di", di, 32'd0); chk("rst.mem_a", 32'(mem_a), 32'd0); chk("rst.mem_do", mem_do, 32'd0);
    rst = 1'b0; mem_ack = 1'b1; mem_di = 32'h99999999;
    tick();
    chk("rst.late_ack_di", di, 32'd0); chk("rst.late_ack_req", 32'(mem_req), 32'd0);
    chk("rst.late_ack_wait", 32'(wait_n), 32'd1);
    set_idle(); tick();

    // Back-to-back reads: restart sampled in the same CE_R as the release.
    bs_n = 1'b0; cs_n = 4'hE; a = 27'h0000010;
    tick(); bs_n = 1'b1; rd_n = 1'b0;
    tick(); chk("b2b.req1", 32'(mem_req), 32'd1); chk("b2b.addr1", 32'(mem_a), 32'h10);
    mem_ack = 1'b1; mem_di = 32'h01010101;
    tick(); chk("b2b.di1", di, 32'h01010101); chk("b2b.wait1", 32'(wait_n), 32'd1);
    mem_ack = 1'b0; bs_n = 1'b0; rd_n = 1'b1; a = 27'h0000020;
    tick(); chk("b2b.rearm_wait", 32'(wait_n), 32'd0); chk("b2b.addr2", 32'(mem_a), 32'h20);
    chk("b2b.rearm_noreq", 32'(mem_req), 32'd0);
    bs_n = 1'b1; rd_n = 1'b0;
    tick(); chk("b2b.req2", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_di = 32'h02020202;
    tick(); chk("b2b.di2", di, 32'h02020202); chk("b2b.req2_drop", 32'(mem_req), 32'd0);
    set_idle(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sh2_ext_bus_bridge.md
Name: sh2_ext_bus_bridge

Overview:
- Sits directly downstream of the SH7604 external bus pins.
- Decodes CS0..CS3-qualified bus cycles into a single request/acknowledge memory port. Drives the CPU's WAIT_N until the slave answers and returns read data on the CPU DI bus.
- A timeout terminates cycles that are never acknowledged, so the CPU cannot hang. One instance per SH-2 (master/slave).

Parameters:
- TIMEOUT, 255: CLK cycles in BUSY without MEM_ACK before forced termination. Legal range 1..1023.
- ERR_DATA, 32'hFFFFFFFF: read data returned on timeout.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset; synchronous and active-high
- CE_R  in  1  CPU rising clock enable; all SH-side pin sampling is qualified by it
- A  in  27  CPU address
- DO  in  32  CPU write data
- DI  out  32  read data to CPU
- BS_N  in  1  bus start strobe
- CS_N  in  4  CS3..CS0 area selects
- RD_WR_N  in  1  1 = read, 0 = write
- RD_N  in  1  read strobe
- WE_N  in  4  byte write strobes; bit 3 = D31..24
- WAIT_N  out  1  wait request to CPU
- MEM_A  out  27  latched address
- MEM_DO  out  32  latched write data
- MEM_BE  out  4  byte enables; 4'hF on reads
- MEM_WR  out  1  1 = write
- MEM_AREA  out  2  index of selected CS
- MEM_REQ  out  1  request, level
- MEM_ACK  in  1  single-cycle acknowledge
- MEM_DI  in  32  read data, valid with MEM_ACK
- BUS_ERR  out  1  one-CLK pulse on timeout

Behaviour:
- Reset values:
  - MEM_REQ=0, WAIT_N=1, BUS_ERR=0, MEM_WR=0.
  - DI, MEM_A, MEM_DO = 0; MEM_BE=0; MEM_AREA=0.
  - State IDLE; timeout counter 0.
- Reset mid-cycle returns to IDLE next CLK and drops MEM_REQ immediately. A late MEM_ACK is ignored.
- States: IDLE, ARM, BUSY, DONE.
- IDLE:
  - Transition on CE_R with BS_N=0 and CS_N!=4'hF.
  - Latch A and RD_WR_N.
  - Set MEM_AREA to the lowest-index asserted CS (CS0 has priority).
  - Drive WAIT_N=0 from the next CLK. Go to ARM.
- ARM, on CE_R:
  - Read (RD_WR_N=1): when RD_N=0, set MEM_BE=4'hF and MEM_WR=0.
  - Write: when WE_N!=4'hF, latch DO into MEM_DO, set MEM_BE=~WE_N and MEM_WR=1.
  - In either case assert MEM_REQ on the next CLK, clear the counter, and go to BUSY.
  - If CS_N returns to 4'hF first (aborted cycle), go to IDLE with WAIT_N=1 and no request issued.
- BUSY:
  - MEM_REQ held at 1. Counter increments every CLK; it is not gated by CE_R.
  - On MEM_ACK: drop MEM_REQ, set WAIT_N=1. For reads, DI<=MEM_DI in the same edge. Go to DONE.
  - On counter==TIMEOUT-1 without ACK: drop MEM_REQ, set WAIT_N=1 and BUS_ERR=1 for one CLK. For reads, DI<=ERR_DATA. Go to DONE.
  - If ACK and expiry coincide, ACK wins; no BUS_ERR.
- DONE:
  - DI held stable.
  - On CE_R with CS_N=4'hF, go to IDLE.
  - Back-to-back cycles: a new BS_N=0 sampled in the same CE_R as CS release is taken. The transition goes directly to ARM with fresh latches.
- Request/ack latency:
  - Minimum from BS_N sample to MEM_REQ: 2 CE_R periods.
  - MEM_ACK to WAIT_N=1: 1 CLK.
- WAIT_N is low only in ARM and BUSY.
- MEM_ACK outside BUSY is ignored.
- MEM_A/MEM_DO/MEM_BE/MEM_WR/MEM_AREA stay constant while MEM_REQ=1.
- Counter saturates. It is 10 bits wide (covers TIMEOUT up to 1023).

Decomposition:
- Shared package SH7604_PKG gets:
  - the state enum BridgeState_t {BR_IDLE, BR_ARM, BR_BUSY, BR_DONE};
  - the area type BridgeArea_t (2 bits).
- One sub-module is natural: sh2_ext_bus_bridge_tmo, the timeout counter.
  - Inputs: clear, run.
  - Output: expire.
  - Parameterised by TIMEOUT.

Test Plan:
- Read, CS0: BS_N=0 at A=27'h0000100, RD_N=0; MEM_ACK 5 CLK after MEM_REQ with MEM_DI=32'h12345678 -> MEM_REQ for 5 CLK, MEM_AREA=0, MEM_BE=F, DI=32'h12345678, WAIT_N high 1 CLK after ACK, BUS_ERR never set.
- Byte write, CS2: WE_N=4'b1101, DO=32'hAABBCCDD -> MEM_WR=1, MEM_BE=4'b0010, MEM_DO=32'hAABBCCDD, MEM_AREA=2.
- Timeout (TIMEOUT=16): read issued, no ACK -> MEM_REQ drops after exactly 16 CLK, BUS_ERR pulses once, DI=32'hFFFFFFFF; an ACK arriving later is ignored.
- Coincident ACK and expiry, plus CS0 and CS3 both low -> DI=MEM_DI, no BUS_ERR, MEM_AREA=0.
- Abort and reset: CS_N released while in ARM -> no MEM_REQ, WAIT_N=1. In a separate case, RST=1 for one CLK during BUSY -> MEM_REQ=0 next CLK and all outputs at reset values.
- Back-to-back reads: new BS_N in the same CE_R as CS release -> second MEM_REQ issued, address relatched, no lost cycle.
